div_clock_monitor: RTL and testbench

//  Receive-side companion to the ripple clock divider. Takes a divided (slow, asynchronous)

---
 rtl/div_clock_pkg.sv | 21 ++
 rtl/div_clock_monitor_sync_edge_detect.sv | 37 +++
 rtl/div_clock_monitor.sv | 132 +++++++++++++
 tb/tb_div_clock_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_clock_pkg.sv
// Shared state encoding and arithmetic helpers for the divided-clock monitor.
package div_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  // Operands are zero-extended up to 32 bits; the extra sign bit keeps the difference exact.
  localparam int DIFF_W = 33;

  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-2:0] a,
                                                 input logic [DIFF_W-2:0] b);
    logic signed [DIFF_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DIFF_W-1] ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

endpackage

// File: rtl/div_clock_monitor_sync_edge_detect.sv
// Synchronizes the divided clock into the fast domain and emits registered rise/fall ticks.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise_tick,
  output logic fall_tick
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   lvl_p1;
  logic [SYNC_STAGES:0]   vld_p0;
  logic                   lvl_p0;

  assign lvl_p0 = sync_p0[SYNC_STAGES-1];

  // Ticks stay masked until the delay flop holds a post-reset sample, so a level that was
  // already present at reset release is not mistaken for an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0   <= '0;
      lvl_p1    <= 1'b0;
      vld_p0    <= '0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync_p0   <= {sync_p0[SYNC_STAGES-2:0], din};
      lvl_p1    <= lvl_p0;
      vld_p0    <= {vld_p0[SYNC_STAGES-1:0], 1'b1};
      rise_tick <= vld_p0[SYNC_STAGES] &  lvl_p0 & ~lvl_p1;
      fall_tick <= vld_p0[SYNC_STAGES] & ~lvl_p0 &  lvl_p1;
    end
  end

endmodule

// File: rtl/div_clock_monitor.sv
// Divided-clock monitor: period measurement, lock and loss detection from synchronized ticks.
// Optional DIV_CLOCK_DUTY_MEAS_EN adds the high_time output (rise-to-fall interval).
module div_clock_monitor
  import div_clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 24,
  parameter int TIMEOUT     = 2**20,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                div_clock_in,
  output logic                rise_tick,
  output logic                fall_tick,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                clk_lost
`ifdef DIV_CLOCK_DUTY_MEAS_EN
  ,
  output logic [PERIOD_W-1:0] high_time
`endif
);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
  localparam int                  GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0]   LOCK_C    = GOOD_W'(LOCK_COUNT);

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] prev;
  logic [GOOD_W-1:0]   good;
  logic                has_prev;
  logic                match;
  logic                timeout;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .din      (div_clock_in),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  assign match   = abs_diff(32'(cnt), 32'(prev)) <= DIFF_W'(TOL);
  assign timeout = (cnt == TIMEOUT_C);

  // Interval counter: restarts at 1 on every rise so it reads the exact interval at the next rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise_tick) begin
      cnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      clk_lost     <= 1'b0;
      prev         <= '0;
      good         <= '0;
      has_prev     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE, LOST: begin
          if (rise_tick) begin
            state    <= MEASURE;
            clk_lost <= 1'b0;
            has_prev <= 1'b0;
            good     <= '0;
          end else if (state == IDLE && timeout) begin
            state    <= LOST;
            clk_lost <= 1'b1;
            locked   <= 1'b0;
            good     <= '0;
          end
        end
        MEASURE, LOCKED: begin
          if (rise_tick) begin
            period       <= cnt;
            period_valid <= 1'b1;
            prev         <= cnt;
            has_prev     <= 1'b1;
            if (has_prev) begin
              if (!match) begin
                good   <= '0;
                state  <= MEASURE;
                locked <= 1'b0;
              end else if (state == MEASURE) begin
                good <= good + 1'b1;
                if (good + 1'b1 == LOCK_C) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
          end else if (timeout) begin
            state    <= LOST;
            clk_lost <= 1'b1;
            locked   <= 1'b0;
            good     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_CLOCK_DUTY_MEAS_EN
  // cnt already counts from the last rise, so at a fall it is the high time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_time <= '0;
    end else if (fall_tick) begin
      high_time <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_div_clock_monitor.sv
// Directed bench for div_clock_monitor (SYNC_STAGES=2, PERIOD_W=16, TIMEOUT=1000, LOCK_COUNT=4, TOL=1).
module tb_div_clock_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        div_clock_in;
  logic        rise_tick;
  logic        fall_tick;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        clk_lost;
`ifdef DIV_CLOCK_DUTY_MEAS_EN
  logic [15:0] high_time;
`endif

  int tests = 0;
  int fails = 0;

  div_clock_monitor #(
    .SYNC_STAGES(2),
    .PERIOD_W   (16),
    .TIMEOUT    (1000),
    .LOCK_COUNT (4),
    .TOL        (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .div_clock_in(div_clock_in),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .clk_lost    (clk_lost)
`ifdef DIV_CLOCK_DUTY_MEAS_EN
    ,
    .high_time   (high_time)
`endif
  );

  always #5 clock = ~clock;

  // Divided-clock source: one high/low pair per period, taken from the queue or the defaults.
  int   q_h[$];
  int   q_l[$];
  int   def_h = 32;
  int   def_l = 32;
  bit   run = 1'b0;
  logic hold_lvl = 1'b0;
  int   ph = 0;
  int   cur_h = 32;
  int   cur_l = 32;

  initial begin
    div_clock_in = 1'b0;
    forever begin
      @(negedge clock);
      if (!run) begin
        div_clock_in = hold_lvl;
        ph = 0;
      end else begin
        if (ph == 0) begin
          if (q_h.size() > 0) begin
            cur_h = q_h.pop_front();
            cur_l = q_l.pop_front();
          end else begin
            cur_h = def_h;
            cur_l = def_l;
          end
        end
        div_clock_in = (ph < cur_h);
        ph = (ph + 1 == cur_h + cur_l) ? 0 : ph + 1;
      end
    end
  end

  int cyc = 0;
  int last_rise = 0;
  int rise_gap = 0;
  int fall_off = 0;
  int n_rise = 0;
  int n_fall = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rise_tick) begin
      rise_gap  <= cyc - last_rise;
      last_rise <= cyc;
      n_rise    <= n_rise + 1;
    end
    if (fall_tick) begin
      fall_off <= cyc - last_rise;
      n_fall   <= n_fall + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the next rise tick, when the FSM has consumed it.
  task automatic wait_rise(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rise_tick !== 1'b1 && n < 3000);
    check({tag, "_seen"}, 32'(rise_tick), 32'd1);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_rise", 32'(rise_tick), 0);
    check("rst_fall", 32'(fall_tick), 0);
    check("rst_period", 32'(period), 0);
    check("rst_pv", 32'(period_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_lost", 32'(clk_lost), 0);

    // 1: input idle -> clk_lost exactly when cnt reaches 1000
    repeat (1000) @(negedge clock);
    check("t1_lost_before", 32'(clk_lost), 0);
    @(negedge clock);
    check("t1_lost_at", 32'(clk_lost), 1);
    check("t1_locked", 32'(locked), 0);
    check("t1_no_rise", 32'(n_rise), 0);
    check("t1_no_fall", 32'(n_fall), 0);

    // 2: 32H/32L square wave
    run = 1'b1;
    wait_rise("t2_r1");
    check("t2_r1_lost", 32'(clk_lost), 0);
    check("t2_r1_period", 32'(period), 0);
    check("t2_r1_pv", 32'(period_valid), 0);
    wait_rise("t2_r2");
    check("t2_r2_period", 32'(period), 64);
    check("t2_r2_pv", 32'(period_valid), 1);
    check("t2_gap", 32'(rise_gap), 64);
    check("t2_fall_off", 32'(fall_off), 32);
    check("t2_r2_locked", 32'(locked), 0);
    wait_rise("t2_r3");
    wait_rise("t2_r4");
    wait_rise("t2_r5");
    check("t2_r5_locked", 32'(locked), 0);
    wait_rise("t2_r6");
    check("t2_r6_locked", 32'(locked), 1);
    check("t2_r6_pv", 32'(period_valid), 1);

    // 3: one 67-cycle period while locked, then relock on 64s
    q_h.push_back(35);
    q_l.push_back(32);
    wait_rise("t3_r7");
    check("t3_r7_locked", 32'(locked), 1);
    wait_rise("t3_r8");
    check("t3_r8_period", 32'(period), 67);
    check("t3_r8_locked", 32'(locked), 0);
    wait_rise("t3_r9");
    check("t3_r9_period", 32'(period), 64);
    check("t3_r9_locked", 32'(locked), 0);
    wait_rise("t3_r10");
    wait_rise("t3_r11");
    wait_rise("t3_r12");
    check("t3_r12_locked", 32'(locked), 0);
    wait_rise("t3_r13");
    check("t3_r13_locked", 32'(locked), 1);

    // 4: input stuck high -> lost 1000 cycles after the last rise, then resume
    hold_lvl = 1'b1;
    run = 1'b0;
    repeat (999) @(negedge clock);
    check("t4_lost_before", 32'(clk_lost), 0);
    check("t4_locked_before", 32'(locked), 1);
    @(negedge clock);
    check("t4_lost_at", 32'(clk_lost), 1);
    check("t4_locked_at", 32'(locked), 0);
    run = 1'b1;
    wait_rise("t4_resume");
    check("t4_resume_lost", 32'(clk_lost), 0);
    check("t4_resume_period", 32'(period), 64);
    check("t4_resume_pv", 32'(period_valid), 0);
    wait_rise("t4_next");
    check("t4_next_period", 32'(period), 64);
    check("t4_next_pv", 32'(period_valid), 1);
    wait_rise("t4_m2");
    wait_rise("t4_m3");
    wait_rise("t4_m4");
    wait_rise("t4_m5");
    check("t4_relocked", 32'(locked), 1);

    // 5: asynchronous reset while locked
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t5_async_locked", 32'(locked), 0);
    check("t5_async_period", 32'(period), 0);
    check("t5_async_lost", 32'(clk_lost), 0);
    check("t5_async_pv", 32'(period_valid), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_rise("t5_r1");
    check("t5_r1_period", 32'(period), 0);
    check("t5_r1_pv", 32'(period_valid), 0);
    wait_rise("t5_r2");
    check("t5_r2_period", 32'(period), 64);
    check("t5_r2_pv", 32'(period_valid), 1);
    check("t5_r2_locked", 32'(locked), 0);

    // 6: 20H input, periods alternating 64/65 still lock
    run = 1'b0;
    hold_lvl = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    def_h = 20;
    def_l = 44;
    for (int i = 0; i < 3; i++) begin
      q_h.push_back(20); q_l.push_back(44);
      q_h.push_back(20); q_l.push_back(45);
    end
    run = 1'b1;
    wait_rise("t6_r1");
    check("t6_r1_period", 32'(period), 0);
    wait_rise("t6_r2");
    check("t6_r2_period", 32'(period), 64);
    check("t6_fall_off", 32'(fall_off), 20);
`ifdef DIV_CLOCK_DUTY_MEAS_EN
    check("t6_high_time", 32'(high_time), 20);
`endif
    wait_rise("t6_r3");
    check("t6_r3_period", 32'(period), 65);
    wait_rise("t6_r4");
    wait_rise("t6_r5");
    check("t6_r5_locked", 32'(locked), 0);
    wait_rise("t6_r6");
    check("t6_r6_period", 32'(period), 64);
    check("t6_r6_locked", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
